// File: rtl/wt_mem_req_arbiter.sv
// wt_mem_req_arbiter
// Merges the I$ and D$ memory-side request channels onto one downstream
// memory port. Requests are granted round-robin into a single output
// register. Each request is tagged {src, tid}, where src 0 = I$ and 1 = D$.
// In-flight transactions are limited per source. Returns are registered and
// steered back to the source named in the tag MSB.
//
// Ports
//   clk_i, rst_ni, clr_i     clock, async active-low reset, sync clear
//   icache_req_*             I$ read request channel (valid/ready/addr/tid)
//   dcache_req_*             D$ request channel (valid/ready/we/addr/wdata/be/tid)
//   mem_req_*                downstream request (valid/ready/we/addr/wdata/be/tid)
//   mem_rtrn_*               downstream return (valid/tid/data), no back-pressure
//   icache_rtrn_valid_o      I$ return strobe
//   dcache_rtrn_valid_o      D$ return strobe
//   rtrn_tid_o, rtrn_data_o  shared return payload
//   err_o                    sticky: a return arrived for a source with nothing outstanding
module wt_mem_req_arbiter #(
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 64,
  parameter int RtrnWidth      = 128,
  parameter int TidWidth       = 2,
  parameter int MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,

  input  logic                   icache_req_valid_i,
  output logic                   icache_req_ready_o,
  input  logic [AddrWidth-1:0]   icache_req_addr_i,
  input  logic [TidWidth-1:0]    icache_req_tid_i,

  input  logic                   dcache_req_valid_i,
  output logic                   dcache_req_ready_o,
  input  logic                   dcache_req_we_i,
  input  logic [AddrWidth-1:0]   dcache_req_addr_i,
  input  logic [DataWidth-1:0]   dcache_req_wdata_i,
  input  logic [DataWidth/8-1:0] dcache_req_be_i,
  input  logic [TidWidth-1:0]    dcache_req_tid_i,

  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic                   mem_req_we_o,
  output logic [AddrWidth-1:0]   mem_req_addr_o,
  output logic [DataWidth-1:0]   mem_req_wdata_o,
  output logic [DataWidth/8-1:0] mem_req_be_o,
  output logic [TidWidth:0]      mem_req_tid_o,

  input  logic                   mem_rtrn_valid_i,
  input  logic [TidWidth:0]      mem_rtrn_tid_i,
  input  logic [RtrnWidth-1:0]   mem_rtrn_data_i,

  output logic                   icache_rtrn_valid_o,
  output logic                   dcache_rtrn_valid_o,
  output logic [TidWidth-1:0]    rtrn_tid_o,
  output logic [RtrnWidth-1:0]   rtrn_data_o,
  output logic                   err_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int BeW  = DataWidth / 8;
  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;
  localparam logic [CntW-1:0] CNT_ONE = CntW'(1);
  localparam logic [CntW:0]   CNT_MAX = (CntW + 1)'(MaxOutstanding);

  // request output stage
  logic                 req_valid_q;
  logic                 req_we_q;
  logic [AddrWidth-1:0] req_addr_q;
  logic [DataWidth-1:0] req_wdata_q;
  logic [BeW-1:0]       req_be_q;
  logic [TidWidth:0]    req_tid_q;

  logic                 last_q;
  logic [CntW-1:0]      cnt_i_q;
  logic [CntW-1:0]      cnt_d_q;
  logic                 err_q;

  logic                 rtrn_i_q;
  logic                 rtrn_d_q;
  logic [TidWidth-1:0]  rtrn_tid_q;
  logic [RtrnWidth-1:0] rtrn_data_q;

  logic            can_load;
  logic            handshake;
  logic            stage_i;
  logic            stage_d;
  logic [CntW:0]   used_i;
  logic [CntW:0]   used_d;
  logic            elig_i;
  logic            elig_d;
  logic            grant_i;
  logic            grant_d;
  logic            inc_i;
  logic            inc_d;
  logic            dec_i;
  logic            dec_d;

  assign can_load  = !req_valid_q || mem_req_ready_i;
  assign handshake = req_valid_q && mem_req_ready_i;
  assign stage_i   = req_valid_q && (req_tid_q[TidWidth] == SRC_I);
  assign stage_d   = req_valid_q && (req_tid_q[TidWidth] == SRC_D);

  // A request waiting in the output stage is not counted yet, because the
  // counter only moves on the memory handshake. It still counts toward the
  // limit here. Without this, back-to-back grants would overshoot
  // MaxOutstanding by one.
  assign used_i = {1'b0, cnt_i_q} + {{CntW{1'b0}}, stage_i};
  assign used_d = {1'b0, cnt_d_q} + {{CntW{1'b0}}, stage_d};

  assign elig_i = icache_req_valid_i && (used_i < CNT_MAX);
  assign elig_d = dcache_req_valid_i && (used_d < CNT_MAX);

  // On a tie, the source that was not granted last time wins.
  assign grant_i = can_load && elig_i && (!elig_d || (last_q == SRC_D));
  assign grant_d = can_load && elig_d && (!elig_i || (last_q == SRC_I));

  // Ready is suppressed during clear, so a request is never acknowledged
  // and then dropped.
  assign icache_req_ready_o = grant_i && !clr_i;
  assign dcache_req_ready_o = grant_d && !clr_i;

  assign inc_i = handshake && (req_tid_q[TidWidth] == SRC_I);
  assign inc_d = handshake && (req_tid_q[TidWidth] == SRC_D);
  assign dec_i = mem_rtrn_valid_i && (mem_rtrn_tid_i[TidWidth] == SRC_I);
  assign dec_d = mem_rtrn_valid_i && (mem_rtrn_tid_i[TidWidth] == SRC_D);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_tid_q   <= '0;
      last_q      <= SRC_D;
    end else if (clr_i) begin
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_tid_q   <= '0;
      last_q      <= SRC_D;
    end else if (can_load) begin
      req_valid_q <= grant_i || grant_d;
      if (grant_d) begin
        req_we_q    <= dcache_req_we_i;
        req_addr_q  <= dcache_req_addr_i;
        req_wdata_q <= dcache_req_we_i ? dcache_req_wdata_i : '0;
        req_be_q    <= dcache_req_we_i ? dcache_req_be_i : '0;
        req_tid_q   <= {SRC_D, dcache_req_tid_i};
        last_q      <= SRC_D;
      end else if (grant_i) begin
        req_we_q    <= 1'b0;
        req_addr_q  <= icache_req_addr_i;
        req_wdata_q <= '0;
        req_be_q    <= '0;
        req_tid_q   <= {SRC_I, icache_req_tid_i};
        last_q      <= SRC_I;
      end else begin
        req_we_q    <= 1'b0;
        req_addr_q  <= '0;
        req_wdata_q <= '0;
        req_be_q    <= '0;
        req_tid_q   <= '0;
      end
    end
  end

  // Outstanding counters. A decrement at zero saturates and raises err.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_i_q <= '0;
      cnt_d_q <= '0;
      err_q   <= 1'b0;
    end else if (clr_i) begin
      cnt_i_q <= '0;
      cnt_d_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (inc_i && !dec_i) begin
        cnt_i_q <= cnt_i_q + CNT_ONE;
      end else if (dec_i && !inc_i) begin
        if (cnt_i_q == '0) err_q <= 1'b1;
        else               cnt_i_q <= cnt_i_q - CNT_ONE;
      end
      if (inc_d && !dec_d) begin
        cnt_d_q <= cnt_d_q + CNT_ONE;
      end else if (dec_d && !inc_d) begin
        if (cnt_d_q == '0) err_q <= 1'b1;
        else               cnt_d_q <= cnt_d_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rtrn_i_q    <= 1'b0;
      rtrn_d_q    <= 1'b0;
      rtrn_tid_q  <= '0;
      rtrn_data_q <= '0;
    end else if (clr_i) begin
      rtrn_i_q    <= 1'b0;
      rtrn_d_q    <= 1'b0;
      rtrn_tid_q  <= '0;
      rtrn_data_q <= '0;
    end else begin
      rtrn_i_q <= dec_i;
      rtrn_d_q <= dec_d;
      if (mem_rtrn_valid_i) begin
        rtrn_tid_q  <= mem_rtrn_tid_i[TidWidth-1:0];
        rtrn_data_q <= mem_rtrn_data_i;
      end
    end
  end

  assign mem_req_valid_o     = req_valid_q;
  assign mem_req_we_o        = req_we_q;
  assign mem_req_addr_o      = req_addr_q;
  assign mem_req_wdata_o     = req_wdata_q;
  assign mem_req_be_o        = req_be_q;
  assign mem_req_tid_o       = req_tid_q;
  assign icache_rtrn_valid_o = rtrn_i_q;
  assign dcache_rtrn_valid_o = rtrn_d_q;
  assign rtrn_tid_o          = rtrn_tid_q;
  assign rtrn_data_o         = rtrn_data_q;
  assign err_o               = err_q;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Testbench for wt_mem_req_arbiter with the default parameters
// (64-bit address/data, 128-bit return, 2-bit tid, limit 4).
module tb_wt_mem_req_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         clr_i;
  logic         icache_req_valid_i;
  logic         icache_req_ready_o;
  logic [63:0]  icache_req_addr_i;
  logic [1:0]   icache_req_tid_i;
  logic         dcache_req_valid_i;
  logic         dcache_req_ready_o;
  logic         dcache_req_we_i;
  logic [63:0]  dcache_req_addr_i;
  logic [63:0]  dcache_req_wdata_i;
  logic [7:0]   dcache_req_be_i;
  logic [1:0]   dcache_req_tid_i;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic         mem_req_we_o;
  logic [63:0]  mem_req_addr_o;
  logic [63:0]  mem_req_wdata_o;
  logic [7:0]   mem_req_be_o;
  logic [2:0]   mem_req_tid_o;
  logic         mem_rtrn_valid_i;
  logic [2:0]   mem_rtrn_tid_i;
  logic [127:0] mem_rtrn_data_i;
  logic         icache_rtrn_valid_o;
  logic         dcache_rtrn_valid_o;
  logic [1:0]   rtrn_tid_o;
  logic [127:0] rtrn_data_o;
  logic         err_o;

  wt_mem_req_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
    .icache_req_valid_i(icache_req_valid_i), .icache_req_ready_o(icache_req_ready_o),
    .icache_req_addr_i(icache_req_addr_i), .icache_req_tid_i(icache_req_tid_i),
    .dcache_req_valid_i(dcache_req_valid_i), .dcache_req_ready_o(dcache_req_ready_o),
    .dcache_req_we_i(dcache_req_we_i), .dcache_req_addr_i(dcache_req_addr_i),
    .dcache_req_wdata_i(dcache_req_wdata_i), .dcache_req_be_i(dcache_req_be_i),
    .dcache_req_tid_i(dcache_req_tid_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_be_o(mem_req_be_o),
    .mem_req_tid_o(mem_req_tid_o),
    .mem_rtrn_valid_i(mem_rtrn_valid_i), .mem_rtrn_tid_i(mem_rtrn_tid_i),
    .mem_rtrn_data_i(mem_rtrn_data_i),
    .icache_rtrn_valid_o(icache_rtrn_valid_o), .dcache_rtrn_valid_o(dcache_rtrn_valid_o),
    .rtrn_tid_o(rtrn_tid_o), .rtrn_data_o(rtrn_data_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    clr_i = 1'b0;
    icache_req_valid_i = 1'b0; icache_req_addr_i = 64'h0; icache_req_tid_i = 2'd0;
    dcache_req_valid_i = 1'b0; dcache_req_we_i = 1'b0; dcache_req_addr_i = 64'h0;
    dcache_req_wdata_i = 64'h0; dcache_req_be_i = 8'h0; dcache_req_tid_i = 2'd0;
    mem_req_ready_i = 1'b1;
    mem_rtrn_valid_i = 1'b0; mem_rtrn_tid_i = 3'd0; mem_rtrn_data_i = 128'h0;
  endtask

  // Issue back-to-back requests from one source with ready held high and
  // count how many are accepted before the limit stalls it; then let the
  // output stage drain.
  task automatic fill(input bit src, output int n);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      idle_inputs();
      icache_req_valid_i = !src; icache_req_tid_i = 2'(k);
      dcache_req_valid_i = src;  dcache_req_tid_i = 2'(k);
      #1;
      if (src ? dcache_req_ready_o : icache_req_ready_o) n++;
    end
    @(negedge clk_i); idle_inputs();
    @(negedge clk_i);
  endtask

  task automatic clear_pulse();
    @(negedge clk_i); idle_inputs(); clr_i = 1'b1;
    @(negedge clk_i); clr_i = 1'b0;
  endtask

  typedef struct {
    bit iv; logic [1:0] itid; bit dv; bit dwe; logic [1:0] dtid; bit rdy;
    bit rv; logic [2:0] rtag; logic [15:0] rdat;
    bit e_iry; bit e_dry; bit e_mv; logic [2:0] e_mtid;
    bit e_irv; bit e_drv; logic [1:0] e_rtid; logic [15:0] e_rdat; bit e_err;
  } vec_t;

  vec_t vecs[13];

  // behavioural model state for the random phase
  typedef struct {
    bit v; bit we; logic [63:0] addr; logic [63:0] wdata; logic [7:0] be; logic [2:0] tid;
  } req_t;

  int          q_i[$];
  int          q_d[$];
  bit          m_last;
  req_t        ms;
  bit          m_irv, m_drv;
  logic [1:0]  m_rtid;
  logic [127:0] m_rdata;

  initial begin
    int n;
    //            iv itid dv we dtid rdy rv rtag    rdat      iry dry mv mtid    irv drv rtid rdat      err
    vecs[0]  = '{1, 1,   0, 0, 0,   1,  0, 3'b000, 16'h0,    1,  0,  0, 3'b000, 0,  0,  0,   16'h0,    0};
    vecs[1]  = '{0, 0,   0, 0, 0,   1,  0, 3'b000, 16'h0,    0,  0,  1, 3'b001, 0,  0,  0,   16'h0,    0};
    vecs[2]  = '{1, 2,   1, 0, 1,   1,  0, 3'b000, 16'h0,    0,  1,  0, 3'b000, 0,  0,  0,   16'h0,    0};
    vecs[3]  = '{1, 2,   1, 0, 2,   1,  0, 3'b000, 16'h0,    1,  0,  1, 3'b101, 0,  0,  0,   16'h0,    0};
    vecs[4]  = '{1, 3,   1, 0, 3,   1,  0, 3'b000, 16'h0,    0,  1,  1, 3'b010, 0,  0,  0,   16'h0,    0};
    vecs[5]  = '{0, 0,   0, 0, 0,   1,  0, 3'b000, 16'h0,    0,  0,  1, 3'b111, 0,  0,  0,   16'h0,    0};
    vecs[6]  = '{0, 0,   0, 0, 0,   1,  1, 3'b110, 16'h1234, 0,  0,  0, 3'b000, 0,  0,  0,   16'h0,    0};
    vecs[7]  = '{0, 0,   0, 0, 0,   1,  0, 3'b000, 16'h0,    0,  0,  0, 3'b000, 0,  1,  2,   16'h1234, 0};
    vecs[8]  = '{0, 0,   0, 0, 0,   1,  1, 3'b001, 16'h0055, 0,  0,  0, 3'b000, 0,  0,  0,   16'h0,    0};
    vecs[9]  = '{0, 0,   0, 0, 0,   1,  1, 3'b010, 16'h0066, 0,  0,  0, 3'b000, 1,  0,  1,   16'h0055, 0};
    vecs[10] = '{0, 0,   0, 0, 0,   1,  1, 3'b000, 16'h0,    0,  0,  0, 3'b000, 1,  0,  2,   16'h0066, 0};
    vecs[11] = '{0, 0,   0, 0, 0,   1,  0, 3'b000, 16'h0,    0,  0,  0, 3'b000, 1,  0,  0,   16'h0,    1};
    vecs[12] = '{0, 0,   0, 0, 0,   1,  0, 3'b000, 16'h0,    0,  0,  0, 3'b000, 0,  0,  0,   16'h0,    1};

    idle_inputs();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_mem_valid", 128'(mem_req_valid_o), 128'd0);
    chk("rst_err", 128'(err_o), 128'd0);
    rst_ni = 1'b1;

    // ---- table-driven sequence from reset ----
    for (int k = 0; k < 13; k++) begin
      @(negedge clk_i);
      idle_inputs();
      icache_req_valid_i = vecs[k].iv; icache_req_tid_i = vecs[k].itid;
      icache_req_addr_i  = 64'h8000_0040;
      dcache_req_valid_i = vecs[k].dv; dcache_req_we_i = vecs[k].dwe;
      dcache_req_tid_i   = vecs[k].dtid; dcache_req_addr_i = 64'h1000 + 64'(k);
      mem_req_ready_i    = vecs[k].rdy;
      mem_rtrn_valid_i   = vecs[k].rv; mem_rtrn_tid_i = vecs[k].rtag;
      mem_rtrn_data_i    = {112'h0, vecs[k].rdat};
      #1;
      chk($sformatf("v%0d_icache_ready", k), 128'(icache_req_ready_o), 128'(vecs[k].e_iry));
      chk($sformatf("v%0d_dcache_ready", k), 128'(dcache_req_ready_o), 128'(vecs[k].e_dry));
      chk($sformatf("v%0d_mem_valid", k), 128'(mem_req_valid_o), 128'(vecs[k].e_mv));
      if (vecs[k].e_mv) begin
        chk($sformatf("v%0d_mem_tid", k), 128'(mem_req_tid_o), 128'(vecs[k].e_mtid));
        chk($sformatf("v%0d_mem_we", k), 128'(mem_req_we_o), 128'd0);
        chk($sformatf("v%0d_mem_be", k), 128'(mem_req_be_o), 128'd0);
      end
      chk($sformatf("v%0d_i_rtrn", k), 128'(icache_rtrn_valid_o), 128'(vecs[k].e_irv));
      chk($sformatf("v%0d_d_rtrn", k), 128'(dcache_rtrn_valid_o), 128'(vecs[k].e_drv));
      if (vecs[k].e_irv || vecs[k].e_drv) begin
        chk($sformatf("v%0d_rtrn_tid", k), 128'(rtrn_tid_o), 128'(vecs[k].e_rtid));
        chk($sformatf("v%0d_rtrn_data", k), rtrn_data_o, {112'h0, vecs[k].e_rdat});
      end
      chk($sformatf("v%0d_err", k), 128'(err_o), 128'(vecs[k].e_err));
    end
    chk("icache_addr_path", 128'(mem_req_addr_o), 128'd0);

    // ---- clear: err drops, request dropped, ready suppressed ----
    @(negedge clk_i); idle_inputs(); clr_i = 1'b1; icache_req_valid_i = 1'b1;
    #1;
    chk("clr_ready_gated", 128'(icache_req_ready_o), 128'd0);
    chk("clr_err_before", 128'(err_o), 128'd1);
    @(negedge clk_i); idle_inputs();
    #1;
    chk("clr_err_after", 128'(err_o), 128'd0);
    chk("clr_mem_valid", 128'(mem_req_valid_o), 128'd0);

    // ---- outstanding limit ----
    fill(1'b0, n);
    chk("limit_i_grants", 128'(n), 128'd4);
    @(negedge clk_i); idle_inputs(); icache_req_valid_i = 1'b1; dcache_req_valid_i = 1'b1;
    #1;
    chk("limit_i_stalled", 128'(icache_req_ready_o), 128'd0);
    chk("limit_d_granted", 128'(dcache_req_ready_o), 128'd1);
    @(negedge clk_i); idle_inputs(); icache_req_valid_i = 1'b1;
    mem_rtrn_valid_i = 1'b1; mem_rtrn_tid_i = 3'b010;
    #1;
    chk("limit_i_still_full", 128'(icache_req_ready_o), 128'd0);
    @(negedge clk_i); idle_inputs(); icache_req_valid_i = 1'b1;
    #1;
    chk("limit_i_after_rtrn", 128'(icache_req_ready_o), 128'd1);
    chk("limit_rtrn_strobe", 128'(icache_rtrn_valid_o), 128'd1);
    chk("limit_rtrn_tid", 128'(rtrn_tid_o), 128'd2);
    @(negedge clk_i); idle_inputs();
    // D$ had one request before the clear and one after; the clear must
    // have zeroed the earlier one.
    fill(1'b1, n);
    chk("limit_d_grants", 128'(n), 128'd3);

    // ---- simultaneous handshake and return keeps the count ----
    @(negedge clk_i); idle_inputs(); mem_rtrn_valid_i = 1'b1; mem_rtrn_tid_i = 3'b100;
    @(negedge clk_i); idle_inputs(); dcache_req_valid_i = 1'b1; dcache_req_tid_i = 2'd3;
    #1;
    chk("sim_d_granted", 128'(dcache_req_ready_o), 128'd1);
    @(negedge clk_i); idle_inputs(); mem_rtrn_valid_i = 1'b1; mem_rtrn_tid_i = 3'b101;
    mem_rtrn_data_i = 128'hABCD;
    #1;
    chk("sim_hs_valid", 128'(mem_req_valid_o), 128'd1);
    chk("sim_hs_tid", 128'(mem_req_tid_o), 128'b111);
    @(negedge clk_i); idle_inputs();
    #1;
    chk("sim_d_rtrn", 128'(dcache_rtrn_valid_o), 128'd1);
    chk("sim_i_rtrn", 128'(icache_rtrn_valid_o), 128'd0);
    chk("sim_rtrn_tid", 128'(rtrn_tid_o), 128'd1);
    chk("sim_rtrn_data", rtrn_data_o, 128'hABCD);
    fill(1'b1, n);
    chk("sim_d_room", 128'(n), 128'd1);

    // ---- D$ store held under back-pressure ----
    clear_pulse();
    @(negedge clk_i); idle_inputs();
    dcache_req_valid_i = 1'b1; dcache_req_we_i = 1'b1; dcache_req_addr_i = 64'h2000_0100;
    dcache_req_wdata_i = 64'hDEADBEEF_CAFEF00D; dcache_req_be_i = 8'hFF; dcache_req_tid_i = 2'd2;
    mem_req_ready_i = 1'b0;
    #1;
    chk("st_accept", 128'(dcache_req_ready_o), 128'd1);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk_i); idle_inputs();
      dcache_req_valid_i = 1'b1; dcache_req_we_i = 1'b0; dcache_req_addr_i = 64'h3000_0000;
      dcache_req_wdata_i = 64'h1111_2222_3333_4444; dcache_req_be_i = 8'h0F; dcache_req_tid_i = 2'd2;
      mem_req_ready_i = (j == 4);
      #1;
      chk($sformatf("st%0d_valid", j), 128'(mem_req_valid_o), 128'd1);
      chk($sformatf("st%0d_we", j), 128'(mem_req_we_o), 128'd1);
      chk($sformatf("st%0d_addr", j), 128'(mem_req_addr_o), 128'h2000_0100);
      chk($sformatf("st%0d_wdata", j), 128'(mem_req_wdata_o), 128'hDEADBEEF_CAFEF00D);
      chk($sformatf("st%0d_be", j), 128'(mem_req_be_o), 128'hFF);
      chk($sformatf("st%0d_tid", j), 128'(mem_req_tid_o), 128'b110);
      chk($sformatf("st%0d_second_ready", j), 128'(dcache_req_ready_o), 128'(j == 4));
    end
    @(negedge clk_i); idle_inputs();
    #1;
    chk("st_load_addr", 128'(mem_req_addr_o), 128'h3000_0000);
    chk("st_load_we", 128'(mem_req_we_o), 128'd0);
    chk("st_load_wdata", 128'(mem_req_wdata_o), 128'd0);
    chk("st_load_be", 128'(mem_req_be_o), 128'd0);

    // ---- randomized traffic against a transaction-level model ----
    clear_pulse();
    q_i.delete(); q_d.delete();
    m_last = 1'b1;
    ms = '{v: 1'b0, we: 1'b0, addr: 64'h0, wdata: 64'h0, be: 8'h0, tid: 3'h0};
    m_irv = 1'b0; m_drv = 1'b0; m_rtid = 2'd0; m_rdata = 128'h0;
    for (int c = 0; c < 400; c++) begin
      int  infl_i, infl_d;
      bit  ok_i, ok_d, room, gi, gd, rv;
      bit  rsrc;
      int  idx;
      logic [2:0] rtag;
      @(negedge clk_i);
      idle_inputs();
      // transactions in flight per source: handshaken ones plus the one
      // waiting in the output stage
      infl_i = q_i.size() + ((ms.v && !ms.tid[2]) ? 1 : 0);
      infl_d = q_d.size() + ((ms.v && ms.tid[2]) ? 1 : 0);
      icache_req_valid_i = ($urandom_range(0, 99) < 60);
      icache_req_addr_i  = {$urandom, $urandom};
      icache_req_tid_i   = 2'($urandom);
      dcache_req_valid_i = ($urandom_range(0, 99) < 60);
      dcache_req_we_i    = 1'($urandom);
      dcache_req_addr_i  = {$urandom, $urandom};
      dcache_req_wdata_i = {$urandom, $urandom};
      dcache_req_be_i    = 8'($urandom);
      dcache_req_tid_i   = 2'($urandom);
      mem_req_ready_i    = ($urandom_range(0, 99) < 70);
      rv = 1'b0; rtag = 3'd0;
      if ((q_i.size() + q_d.size() > 0) && ($urandom_range(0, 99) < 45)) begin
        if (q_i.size() == 0)      rsrc = 1'b1;
        else if (q_d.size() == 0) rsrc = 1'b0;
        else                      rsrc = 1'($urandom);
        if (rsrc) begin
          idx = $urandom_range(0, q_d.size() - 1); rtag = {1'b1, 2'(q_d[idx])}; q_d.delete(idx);
        end else begin
          idx = $urandom_range(0, q_i.size() - 1); rtag = {1'b0, 2'(q_i[idx])}; q_i.delete(idx);
        end
        rv = 1'b1;
      end
      mem_rtrn_valid_i = rv; mem_rtrn_tid_i = rtag;
      mem_rtrn_data_i  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      ok_i = icache_req_valid_i && (infl_i < 4);
      ok_d = dcache_req_valid_i && (infl_d < 4);
      room = !ms.v || mem_req_ready_i;
      gi = room && ok_i && (!ok_d || m_last);
      gd = room && ok_d && (!ok_i || !m_last);
      chk("rnd_icache_ready", 128'(icache_req_ready_o), 128'(gi));
      chk("rnd_dcache_ready", 128'(dcache_req_ready_o), 128'(gd));
      chk("rnd_mem_valid", 128'(mem_req_valid_o), 128'(ms.v));
      if (ms.v) begin
        chk("rnd_mem_req", {mem_req_we_o, mem_req_tid_o, mem_req_be_o, mem_req_addr_o, mem_req_wdata_o},
            {ms.we, ms.tid, ms.be, ms.addr, ms.wdata});
      end
      chk("rnd_rtrn_valid", 128'({icache_rtrn_valid_o, dcache_rtrn_valid_o}), 128'({m_irv, m_drv}));
      if (m_irv || m_drv) begin
        chk("rnd_rtrn_tid", 128'(rtrn_tid_o), 128'(m_rtid));
        chk("rnd_rtrn_data", rtrn_data_o, m_rdata);
      end
      chk("rnd_err", 128'(err_o), 128'd0);
      // advance the model to the next clock
      if (ms.v && mem_req_ready_i) begin
        if (ms.tid[2]) q_d.push_back(int'(ms.tid[1:0]));
        else           q_i.push_back(int'(ms.tid[1:0]));
      end
      m_irv = rv && !rtag[2];
      m_drv = rv && rtag[2];
      if (rv) begin
        m_rtid = rtag[1:0]; m_rdata = mem_rtrn_data_i;
      end
      if (room) begin
        if (gd) begin
          ms.v = 1'b1; ms.we = dcache_req_we_i; ms.addr = dcache_req_addr_i;
          ms.wdata = dcache_req_we_i ? dcache_req_wdata_i : 64'h0;
          ms.be = dcache_req_we_i ? dcache_req_be_i : 8'h0;
          ms.tid = {1'b1, dcache_req_tid_i}; m_last = 1'b1;
        end else if (gi) begin
          ms.v = 1'b1; ms.we = 1'b0; ms.addr = icache_req_addr_i; ms.wdata = 64'h0;
          ms.be = 8'h0; ms.tid = {1'b0, icache_req_tid_i}; m_last = 1'b0;
        end else begin
          ms.v = 1'b0;
        end
      end
    end

    @(negedge clk_i); idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
